// File: rtl/uart_stream_master.sv
// Bus master that initialises an iob_uart, polls RX bytes into a small FIFO stream and
// serialises a TX byte stream into TXDATA writes. Optional echo of RX bytes: UART_ECHO_EN.
module uart_stream_master #(
  parameter int UART_ADDR_W    = 3,
  parameter int DATA_W         = 32,
  parameter int RX_FIFO_DEPTH  = 4,
  parameter int ADDR_SOFTRESET = 0,
  parameter int ADDR_DIV       = 1,
  parameter int ADDR_TXDATA    = 2,
  parameter int ADDR_TXEN      = 3,
  parameter int ADDR_TXREADY   = 4,
  parameter int ADDR_RXDATA    = 5,
  parameter int ADDR_RXEN      = 6,
  parameter int ADDR_RXREADY   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            div,
  input  logic                   init_start,
  output logic                   init_done,
  output logic [7:0]             rx_tdata,
  output logic                   rx_tvalid,
  input  logic                   rx_tready,
  input  logic [7:0]             tx_tdata,
  input  logic                   tx_tvalid,
  output logic                   tx_tready,
  output logic                   uart_valid,
  output logic [UART_ADDR_W-1:0] uart_addr,
  output logic [DATA_W-1:0]      uart_wdata,
  output logic [3:0]             uart_wstrb,
  input  logic [DATA_W-1:0]      uart_rdata,
  input  logic                   uart_ready,
  output logic [2:0]             dbg_state
);

  localparam int AW = $clog2(RX_FIFO_DEPTH);
`ifdef UART_ECHO_EN
  localparam bit ECHO_EN = 1'b1;
`else
  localparam bit ECHO_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_POLL_RX, S_READ_RX, S_POLL_TX, S_WRITE_TX
  } state_e;

  state_e                 state_q, state_d;
  logic                   valid_q, valid_d;
  logic [UART_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [3:0]             wstrb_q, wstrb_d;
  logic [2:0]             step_q, step_d;
  logic                   init_done_q, init_done_d;
  logic                   echo_valid_q, echo_valid_d;
  logic [7:0]             echo_data_q, echo_data_d;
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]             fifo_mem [RX_FIFO_DEPTH];

  logic                   launch, launch_write, push, pop, fifo_full, fifo_empty, tx_accept;
  logic [UART_ADDR_W-1:0] launch_addr;
  logic [DATA_W-1:0]      launch_wdata;
  logic                   unused_rdata;

  assign unused_rdata = ^uart_rdata[DATA_W-1:8];

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rx_tvalid  = init_done_q & ~fifo_empty;
  assign rx_tdata   = rx_tvalid ? fifo_mem[rd_ptr_q[AW-1:0]] : 8'h00;
  assign pop        = rx_tvalid & rx_tready;

  // Bus handshake: a request is launched only while valid_q=0, held unchanged while
  // valid_q=1, and retired in the cycle uart_ready=1; valid then drops for one cycle.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    step_d       = step_q;
    init_done_d  = init_done_q;
    echo_valid_d = echo_valid_q;
    echo_data_d  = echo_data_q;
    launch       = 1'b0;
    launch_write = 1'b0;
    launch_addr  = '0;
    launch_wdata = '0;
    push         = 1'b0;
    tx_accept    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_INIT;
          step_d  = 3'd0;
        end
      end
      S_INIT: begin
        if (!valid_q) begin
          launch       = 1'b1;
          launch_write = 1'b1;
          case (step_q)
            3'd0:    begin launch_addr = UART_ADDR_W'(ADDR_SOFTRESET); launch_wdata = DATA_W'(1); end
            3'd1:    begin launch_addr = UART_ADDR_W'(ADDR_SOFTRESET); launch_wdata = DATA_W'(0); end
            3'd2:    begin launch_addr = UART_ADDR_W'(ADDR_DIV);       launch_wdata = DATA_W'(div); end
            3'd3:    begin launch_addr = UART_ADDR_W'(ADDR_TXEN);      launch_wdata = DATA_W'(1); end
            default: begin launch_addr = UART_ADDR_W'(ADDR_RXEN);      launch_wdata = DATA_W'(1); end
          endcase
        end else if (uart_ready) begin
          valid_d = 1'b0;
          if (step_q == 3'd4) begin
            init_done_d = 1'b1;
            state_d     = S_POLL_RX;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      S_POLL_RX: begin
        if (!valid_q) begin
          // A full FIFO or a pending echo must not accept another byte
          if (fifo_full || echo_valid_q) begin
            state_d = S_POLL_TX;
          end else begin
            launch      = 1'b1;
            launch_addr = UART_ADDR_W'(ADDR_RXREADY);
          end
        end else if (uart_ready) begin
          valid_d = 1'b0;
          state_d = uart_rdata[0] ? S_READ_RX : S_POLL_TX;
        end
      end
      S_READ_RX: begin
        if (!valid_q) begin
          launch      = 1'b1;
          launch_addr = UART_ADDR_W'(ADDR_RXDATA);
        end else if (uart_ready) begin
          valid_d = 1'b0;
          push    = ~fifo_full;
          if (ECHO_EN) begin
            echo_valid_d = 1'b1;
            echo_data_d  = uart_rdata[7:0];
          end
          state_d = S_POLL_TX;
        end
      end
      S_POLL_TX: begin
        if (!valid_q) begin
          if (echo_valid_q || tx_tvalid) begin
            launch      = 1'b1;
            launch_addr = UART_ADDR_W'(ADDR_TXREADY);
          end else begin
            state_d = S_POLL_RX;
          end
        end else if (uart_ready) begin
          valid_d = 1'b0;
          state_d = uart_rdata[0] ? S_WRITE_TX : S_POLL_RX;
        end
      end
      S_WRITE_TX: begin
        if (!valid_q) begin
          if (echo_valid_q || tx_tvalid) begin
            launch       = 1'b1;
            launch_write = 1'b1;
            launch_addr  = UART_ADDR_W'(ADDR_TXDATA);
            launch_wdata = echo_valid_q ? DATA_W'(echo_data_q) : DATA_W'(tx_tdata);
          end else begin
            state_d = S_POLL_RX;
          end
        end else if (uart_ready) begin
          valid_d = 1'b0;
          if (echo_valid_q) echo_valid_d = 1'b0;
          else              tx_accept    = 1'b1;
          state_d = S_POLL_RX;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      valid_d = 1'b1;
      addr_d  = launch_addr;
      wdata_d = launch_wdata;
      wstrb_d = launch_write ? 4'hF : 4'h0;
    end

    wr_ptr_d = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      valid_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      step_q       <= 3'd0;
      init_done_q  <= 1'b0;
      echo_valid_q <= 1'b0;
      echo_data_q  <= 8'h00;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      step_q       <= step_d;
      init_done_q  <= init_done_d;
      echo_valid_q <= echo_valid_d;
      echo_data_q  <= echo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= uart_rdata[7:0];
  end

  assign uart_valid = valid_q;
  assign uart_addr  = addr_q;
  assign uart_wdata = wdata_q;
  assign uart_wstrb = wstrb_q;
  assign init_done  = init_done_q;
  assign tx_tready  = tx_accept;
  assign dbg_state  = state_q;

endmodule
